// File: rtl/player_pkg.sv
// Shared player constants: playfield geometry, colours, ship sprite and default placement.
package player_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned SHIP_W   = 2;
  localparam int unsigned SHIP_H   = 3;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned SPRITE_N = SHIP_W * SHIP_H;

  localparam logic [COLOUR_W-1:0] C_BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] C_GREEN = 3'b010;
  localparam logic [COLOUR_W-1:0] C_WHITE = 3'b111;

  // Nose-right ship indexed by {add_y, add_x}; entry 0 is the top-left pixel
  localparam logic [SPRITE_N-1:0][COLOUR_W-1:0] SPRITE = {
    C_GREEN, C_BLACK,   // row 2
    C_WHITE, C_WHITE,   // row 1
    C_GREEN, C_BLACK    // row 0
  };

  localparam int unsigned PLAYER_X_DEF = 4;
  localparam int unsigned Y_INIT_DEF   = 58;
  localparam int unsigned Y_MAX_DEF    = SCREEN_H - SHIP_H;

endpackage

// File: rtl/player_sprite_rom.sv
// Combinational ship colour lookup; the unused offset row 3 reads as black.
module player_sprite_rom
  import player_pkg::*;
(
  input  logic                add_x,
  input  logic [1:0]          add_y,
  output logic [COLOUR_W-1:0] colour_c
);

  always_comb begin
    colour_c = C_BLACK;
    if (add_y != 2'd3) colour_c = SPRITE[{add_y, add_x}];
  end

endmodule

// File: rtl/player_datapath.sv
// Ship position register with clamped moves, plus the registered VGA plot stage.
module player_datapath
  import player_pkg::*;
#(
  parameter int unsigned        X_W      = 8,
  parameter int unsigned        Y_W      = 7,
  parameter logic [X_W-1:0]     PLAYER_X = X_W'(PLAYER_X_DEF),
  parameter logic [Y_W-1:0]     Y_INIT   = Y_W'(Y_INIT_DEF),
  parameter logic [Y_W-1:0]     Y_MIN    = '0,
  parameter logic [Y_W-1:0]     Y_MAX    = Y_W'(Y_MAX_DEF)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                y_pos_mod,
  input  logic                y_neg_mod,
  input  logic                add_x,
  input  logic [1:0]          add_y,
  input  logic                write_en,
  output logic [Y_W-1:0]      y_cur,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot
);

  localparam int unsigned YE_W = Y_W + 1;

  logic [YE_W-1:0]     y_ext;
  logic [YE_W-1:0]     y_dec;
  logic [YE_W-1:0]     y_inc;
  logic [Y_W-1:0]      y_eff;
  logic [COLOUR_W-1:0] colour_c;
  logic                draw_c;

  player_sprite_rom u_rom (
    .add_x    (add_x),
    .add_y    (add_y),
    .colour_c (colour_c)
  );

  // Next position, one bit wider so neither end of the range wraps
  always_comb begin
    y_ext = {1'b0, y_cur};
    y_dec = y_ext - YE_W'(1);
    y_inc = y_ext + YE_W'(1);
    y_eff = y_cur;
    if (y_pos_mod && !y_neg_mod) begin
      y_eff = (y_dec[Y_W] || (y_dec < {1'b0, Y_MIN})) ? Y_MIN : y_dec[Y_W-1:0];
    end else if (y_neg_mod && !y_pos_mod) begin
      y_eff = (y_inc > {1'b0, Y_MAX}) ? Y_MAX : y_inc[Y_W-1:0];
    end
  end

  assign draw_c = write_en && (add_y != 2'd3);

  // Pixels use y_eff so a draw coinciding with a move lands at the new position
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y_cur      <= Y_INIT;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
    end else begin
      y_cur <= y_eff;
      plot  <= draw_c;
      if (draw_c) begin
        x_out      <= PLAYER_X + X_W'(add_x);
        y_out      <= y_eff + Y_W'(add_y);
        colour_out <= colour_c;
      end
    end
  end

endmodule

// File: tb/tb_player_datapath.sv
// Scoreboarded bench for player_datapath: every driven cycle queues its expected outputs.
module tb_player_datapath;

  logic       clk;
  logic       reset_n;
  logic       y_pos_mod;
  logic       y_neg_mod;
  logic       add_x;
  logic [1:0] add_y;
  logic       write_en;
  logic [6:0] y_cur;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;

  typedef struct {
    int y_cur;
    int x;
    int y;
    int col;
    int plot;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  int m_y = 58, m_x = 0, m_yo = 0, m_col = 0, m_plot = 0;

  player_datapath dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .y_pos_mod  (y_pos_mod),
    .y_neg_mod  (y_neg_mod),
    .add_x      (add_x),
    .add_y      (add_y),
    .write_en   (write_en),
    .y_cur      (y_cur),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sprite(input int ax, input int ay);
    case ({ay[1:0], ax[0]})
      3'd0:    return 0;
      3'd1:    return 2;
      3'd2:    return 7;
      3'd3:    return 7;
      3'd4:    return 0;
      3'd5:    return 2;
      default: return 0;
    endcase
  endfunction

  // Apply one cycle of inputs and queue what the outputs must be after the next edge
  task automatic drive(input bit rst, input bit up, input bit dn,
                       input int ax, input int ay, input bit we);
    exp_t e;
    int   ny;
    @(negedge clk);
    reset_n   = ~rst;
    y_pos_mod = up;
    y_neg_mod = dn;
    add_x     = ax[0];
    add_y     = ay[1:0];
    write_en  = we;
    if (rst) begin
      m_y = 58; m_x = 0; m_yo = 0; m_col = 0; m_plot = 0;
    end else begin
      ny = m_y;
      if (up && !dn) ny = (m_y == 0) ? 0 : m_y - 1;
      if (dn && !up) ny = (m_y >= 117) ? 117 : m_y + 1;
      m_y = ny;
      if (we && ay != 3) begin
        m_plot = 1;
        m_x    = 4 + ax;
        m_yo   = ny + ay;
        m_col  = sprite(ax, ay);
      end else begin
        m_plot = 0;
      end
    end
    e = '{y_cur: m_y, x: m_x, y: m_yo, col: m_col, plot: m_plot};
    exp_q.push_back(e);
  endtask

  // Scoreboard: one queued expectation per driven edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests++;
      if (int'(y_cur) !== e.y_cur || int'(plot) !== e.plot || int'(x_out) !== e.x ||
          int'(y_out) !== e.y || int'(colour_out) !== e.col) begin
        fails++;
        $display("FAIL scoreboard t=%0t: got y_cur=%0d plot=%0d x=%0d y=%0d col=%0d, want y_cur=%0d plot=%0d x=%0d y=%0d col=%0d",
                 $time, y_cur, plot, x_out, y_out, colour_out,
                 e.y_cur, e.plot, e.x, e.y, e.col);
      end
    end
  end

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    tests++;
    if (y_cur !== 7'd58 || plot !== 1'b0 || x_out !== 8'd0 || y_out !== 7'd0 || colour_out !== 3'd0) begin
      fails++;
      $display("FAIL reset_idle: got y_cur=%0d plot=%0d x=%0d y=%0d col=%0d, want 58 0 0 0 0",
               y_cur, plot, x_out, y_out, colour_out);
    end
  endtask

  task automatic test_up_sequence();
    drive(0, 1, 0, 0, 0, 1);
    @(posedge clk); #2;
    tests++;
    if (x_out !== 8'd4 || y_out !== 7'd57 || colour_out !== 3'b000 || plot !== 1'b1) begin
      fails++;
      $display("FAIL up_first_pixel: got (%0d,%0d,%b) plot=%0d, want (4,57,000) plot=1",
               x_out, y_out, colour_out, plot);
    end
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 2, 1);
    drive(0, 0, 0, 1, 2, 1);
    @(posedge clk); #2;
    tests++;
    if (y_cur !== 7'd57 || x_out !== 8'd5 || y_out !== 7'd59 || colour_out !== 3'b010) begin
      fails++;
      $display("FAIL up_last_pixel: got y_cur=%0d (%0d,%0d,%b), want 57 (5,59,010)",
               y_cur, x_out, y_out, colour_out);
    end
  endtask

  task automatic test_clamp_top();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 58; i++) drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1);
    @(posedge clk); #2;
    tests++;
    if (y_cur !== 7'd0 || y_out !== 7'd0 || plot !== 1'b1) begin
      fails++;
      $display("FAIL clamp_top: got y_cur=%0d y_out=%0d plot=%0d, want 0 0 1", y_cur, y_out, plot);
    end
  endtask

  task automatic test_clamp_bottom();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 2, 1);
    @(posedge clk); #2;
    tests++;
    if (y_cur !== 7'd117 || x_out !== 8'd5 || y_out !== 7'd119 || colour_out !== 3'b010) begin
      fails++;
      $display("FAIL clamp_bottom: got y_cur=%0d (%0d,%0d,%b), want 117 (5,119,010)",
               y_cur, x_out, y_out, colour_out);
    end
  endtask

  task automatic test_simultaneous_and_illegal();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 1);
    drive(0, 1, 1, 1, 1, 0);
    drive(0, 1, 0, 1, 3, 1);
    @(posedge clk); #2;
    tests++;
    if (y_cur !== 7'd58 || plot !== 1'b0 || x_out !== 8'd4 || y_out !== 7'd60 || colour_out !== 3'b111) begin
      fails++;
      $display("FAIL both_moves_illegal_row: got y_cur=%0d plot=%0d (%0d,%0d,%b), want 58 0 (4,60,111)",
               y_cur, plot, x_out, y_out, colour_out);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 0, 0, 1);
    drive(0, 0, 1, 1, 0, 1);
    drive(1, 0, 1, 0, 1, 1);
    @(posedge clk); #2;
    tests++;
    if (y_cur !== 7'd58 || plot !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got y_cur=%0d plot=%0d, want 58 0", y_cur, plot);
    end
    drive(0, 0, 0, 0, 0, 1);
    @(posedge clk); #2;
    tests++;
    if (y_out !== 7'd58 || plot !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_redraw: got y_out=%0d plot=%0d, want 58 1", y_out, plot);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0));
    end
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
  endtask

  initial begin
    reset_n = 1'b0; y_pos_mod = 1'b0; y_neg_mod = 1'b0;
    add_x = 1'b0; add_y = 2'd0; write_en = 1'b0;
    test_reset();
    test_up_sequence();
    test_clamp_top();
    test_clamp_bottom();
    test_simultaneous_and_illegal();
    test_reset_mid();
    test_back_to_back();
    @(posedge clk); #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
